// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam int NREG_DEF   = 32;
  localparam int RAW_DEF    = 5;
  localparam int LL_MAX_DEF = 4;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/hazard_ctrl_sb_ll_scoreboard.sv
// rtl/hazard_ctrl_sb_ll_scoreboard.sv - pending-register scoreboard for long-latency ops
module ll_scoreboard #(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int LL_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            accept,
  input  logic [RAW-1:0]  rd_e,
  input  logic            ll_done,
  input  logic [RAW-1:0]  ll_rd_done,
  output logic [NREG-1:0] pending,
  output logic            ll_full
);

  localparam int CW = $clog2(LL_MAX + 1);

  logic [CW-1:0]   ll_cnt;
  logic [NREG-1:0] pend_next;
  logic            done_eff;

  // A completion with nothing outstanding is spurious; ignoring it keeps the count from wrapping.
  assign done_eff = ll_done && (ll_cnt != '0);
  assign ll_full  = (ll_cnt == CW'(LL_MAX));

  always_comb begin
    pend_next = pending;
    if (ll_done) pend_next[ll_rd_done] = 1'b0;
    if (accept)  pend_next[rd_e] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      ll_cnt  <= '0;
    end else begin
      pending <= pend_next;
      if (accept && !done_eff)      ll_cnt <= ll_cnt + CW'(1);
      else if (!accept && done_eff) ll_cnt <= ll_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - stall/flush/forwarding control with LL scoreboard and stall counter
module hazard_ctrl_sb #(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int LL_MAX = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RAW-1:0]   rs1_d,
  input  logic [RAW-1:0]   rs2_d,
  input  logic [RAW-1:0]   rd_d,
  input  logic             regwrite_d,
  input  logic [RAW-1:0]   rs1_e,
  input  logic [RAW-1:0]   rs2_e,
  input  logic [RAW-1:0]   rd_e,
  input  logic             regwrite_e,
  input  logic [1:0]       resultsrc_e,
  input  logic             pcsrc_e,
  input  logic             ll_issue_e,
  input  logic [RAW-1:0]   rd_m,
  input  logic             regwrite_m,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  input  logic [RAW-1:0]   rd_w,
  input  logic             regwrite_w,
  input  logic             ll_done,
  input  logic [RAW-1:0]   ll_rd_done,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             ll_full,
  output logic [CNT_W-1:0] stall_cycles
);

  import hazard_pkg::*;

  logic [NREG-1:0] pending;
  logic            ll_full_i;
  logic            accept;
  logic            memstall, load_use, ll_raw, ll_waw, ll_block, dhaz;
  logic            unused_regwrite_e;

  assign unused_regwrite_e = regwrite_e;

  function automatic fwd_sel_t fwd_sel(input logic [RAW-1:0] rs);
    if (regwrite_m && rd_m != '0 && rd_m == rs)      return FWD_M;
    else if (regwrite_w && rd_w != '0 && rd_w == rs) return FWD_W;
    else                                             return FWD_RF;
  endfunction

  assign memstall = mem_req_m && !mem_ready_m;
  assign load_use = (resultsrc_e == RESULT_LOAD) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign ll_raw   = ((rs1_d != '0) && pending[rs1_d]) || ((rs2_d != '0) && pending[rs2_d]);
  assign ll_waw   = regwrite_d && (rd_d != '0) && pending[rd_d];
  assign ll_block = ll_issue_e && ll_full_i;
  assign dhaz     = !memstall && !pcsrc_e && (load_use || ll_raw || ll_waw || ll_block);

  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    forward_ae = fwd_sel(rs1_e);
    forward_be = fwd_sel(rs2_e);
    if (!reset) begin
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      flush_w    = 1'b1;
      forward_ae = FWD_RF;
      forward_be = FWD_RF;
    end else if (memstall) begin
      // Whole pipe freezes; a pending branch stays in E until memory completes.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (dhaz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      if (ll_block) stall_e = 1'b1;
      else          flush_e = 1'b1;
    end
  end

  assign accept  = ll_issue_e && !stall_e && !flush_e && (rd_e != '0);
  assign ll_full = reset && ll_full_i;

  ll_scoreboard #(.NREG(NREG), .RAW(RAW), .LL_MAX(LL_MAX)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .rd_e       (rd_e),
    .ll_done    (ll_done),
    .ll_rd_done (ll_rd_done),
    .pending    (pending),
    .ll_full    (ll_full_i)
  );

  always_ff @(posedge clk) begin
    if (!reset)                                  stall_cycles <= '0;
    else if (stall_f && stall_cycles != '1)      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb/tb_hazard_ctrl_sb.sv - directed self-checking bench for hazard_ctrl_sb
module tb_hazard_ctrl_sb;

  localparam int NREG = 32, RAW = 5, LL_MAX = 2, CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [RAW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, ll_rd_done;
  logic           regwrite_d, regwrite_e, pcsrc_e, ll_issue_e, regwrite_m;
  logic           mem_req_m, mem_ready_m, regwrite_w, ll_done;
  logic [1:0]     resultsrc_e, forward_ae, forward_be;
  logic           stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, ll_full;
  logic [CNT_W-1:0] stall_cycles;

  int passed = 0;
  int total  = 0;

  hazard_ctrl_sb #(.NREG(NREG), .RAW(RAW), .LL_MAX(LL_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
    .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .ll_issue_e(ll_issue_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .ll_done(ll_done), .ll_rd_done(ll_rd_done),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .ll_full(ll_full), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_d = '0; regwrite_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; regwrite_e = 1'b0;
    resultsrc_e = 2'b00; pcsrc_e = 1'b0; ll_issue_e = 1'b0;
    rd_m = '0; regwrite_m = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    rd_w = '0; regwrite_w = 1'b0; ll_done = 1'b0; ll_rd_done = '0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(negedge clk);

    // reset forces outputs even with live hazards on the inputs
    regwrite_m = 1'b1; rd_m = 5; rs1_e = 5; mem_req_m = 1'b1;
    #1;
    chk("rst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    chk("rst_flush", {flush_d, flush_e, flush_w}, 3'b111);
    chk("rst_fwd_ae", forward_ae, 2'b00);
    chk("rst_ll_full", ll_full, 1'b0);
    next();
    chk("rst_cycles", stall_cycles, 0);
    chk("rst_pending", dut.u_sb.pending, 0);

    reset = 1'b1;
    idle();
    regwrite_m = 1'b1; rd_m = 5; rs1_e = 5; rs2_e = 5; regwrite_w = 1'b1; rd_w = 5;
    #1;
    chk("fwd_m_prio_a", forward_ae, 2'b10);
    chk("fwd_m_prio_b", forward_be, 2'b10);
    chk("idle_flush", {flush_d, flush_e, flush_w}, 3'b000);
    rd_m = 0;
    #1;
    chk("fwd_w", forward_ae, 2'b01);
    regwrite_w = 1'b0;
    #1;
    chk("fwd_none", forward_ae, 2'b00);
    regwrite_w = 1'b1; rd_w = 0; rs1_e = 0;
    #1;
    chk("fwd_x0", forward_ae, 2'b00);
    next();

    idle();
    resultsrc_e = 2'b01; rd_e = 7; rs2_d = 7;
    #1;
    chk("lu_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b1100);
    chk("lu_flush", {flush_d, flush_e, flush_w}, 3'b010);
    next();
    idle();
    #1;
    chk("lu_release", stall_f, 1'b0);
    chk("lu_cycles", stall_cycles, 1);

    resultsrc_e = 2'b01; rd_e = 7; rs2_d = 7; pcsrc_e = 1'b1;
    #1;
    chk("br_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    chk("br_flush", {flush_d, flush_e, flush_w}, 3'b110);
    next();

    idle();
    mem_req_m = 1'b1; pcsrc_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b1111);
      chk("ms_flush", {flush_d, flush_e, flush_w}, 3'b001);
      next();
    end
    mem_ready_m = 1'b1;
    #1;
    chk("ms_done_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    chk("ms_done_flush", {flush_d, flush_e, flush_w}, 3'b110);
    chk("ms_cycles", stall_cycles, 4);
    next();

    idle();
    ll_issue_e = 1'b1; rd_e = 3;
    #1;
    chk("ll3_ctrl", {stall_e, flush_e}, 2'b00);
    next();
    rd_e = 4;
    #1;
    chk("ll4_not_full", ll_full, 1'b0);
    next();
    chk("ll_pend_34", dut.u_sb.pending, 32'h18);
    chk("ll_full", ll_full, 1'b1);
    rd_e = 5;
    #1;
    chk("ll_full_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b1110);
    chk("ll_full_flush", {flush_d, flush_e, flush_w}, 3'b000);
    next();
    chk("ll_full_pend", dut.u_sb.pending, 32'h18);
    chk("ll_full_cnt", dut.u_sb.ll_cnt, 2);
    chk("ll_full_cycles", stall_cycles, 5);

    idle();
    rs1_d = 3;
    #1;
    chk("raw_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b1100);
    chk("raw_flush", {flush_d, flush_e, flush_w}, 3'b010);
    next();
    ll_done = 1'b1; ll_rd_done = 3;
    #1;
    chk("raw_done_cycle", stall_f, 1'b1);
    next();
    chk("done3_pend", dut.u_sb.pending, 32'h10);
    chk("done3_not_full", ll_full, 1'b0);
    chk("done3_cycles", stall_cycles, 7);
    idle();
    rs1_d = 3;
    #1;
    chk("raw_released", stall_f, 1'b0);
    next();

    idle();
    regwrite_d = 1'b1; rd_d = 4;
    #1;
    chk("waw_stall", {stall_f, stall_d, flush_e}, 3'b111);
    next();

    idle();
    ll_issue_e = 1'b1; rd_e = 3;
    next();
    idle();
    ll_done = 1'b1; ll_rd_done = 4;
    next();
    chk("done4_pend", dut.u_sb.pending, 32'h08);
    ll_done = 1'b1; ll_rd_done = 3; ll_issue_e = 1'b1; rd_e = 3;
    #1;
    chk("same_ctrl", {stall_f, stall_e, flush_e}, 3'b000);
    next();
    chk("same_pend", dut.u_sb.pending, 32'h08);
    chk("same_cnt", dut.u_sb.ll_cnt, 1);

    idle();
    ll_done = 1'b1; ll_rd_done = 3;
    next();
    chk("drain_cnt", dut.u_sb.ll_cnt, 0);
    chk("drain_pend", dut.u_sb.pending, 0);
    next();
    chk("underflow_cnt", dut.u_sb.ll_cnt, 0);

    idle();
    ll_issue_e = 1'b1; rd_e = 3;
    next();
    idle();
    rs1_d = 3;
    repeat (12) next();
    chk("pre_rst_cycles", stall_cycles, 20);
    chk("pre_rst_pend", dut.u_sb.pending, 32'h08);

    reset = 1'b0;
    #1;
    chk("mid_rst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    chk("mid_rst_flush", {flush_d, flush_e, flush_w}, 3'b111);
    next();
    chk("mid_rst_cycles", stall_cycles, 0);
    chk("mid_rst_pend", dut.u_sb.pending, 0);
    chk("mid_rst_cnt", dut.u_sb.ll_cnt, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_no_stall", stall_f, 1'b0);
    next();
    chk("post_rst_cycles", stall_cycles, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
